// File: rtl/adsr_envelope_multi.sv
// Multi-channel ADSR envelope generator sharing one sample-rate tick.
// Each channel runs gated or one-shot (timed sustain); outputs are the top OUT_W amp bits.
module adsr_envelope_multi #(
  parameter int CHANNELS = 4,
  parameter int AMP_W    = 12,
  parameter int OUT_W    = 8,
  parameter int TIME_W   = 16,
  parameter int LEGATO   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [CHANNELS-1:0]       gate,
  input  logic [CHANNELS-1:0]       mode,
  input  logic                      bypass,
  input  logic [AMP_W-1:0]          attack_step,
  input  logic [AMP_W-1:0]          decay_step,
  input  logic [AMP_W-1:0]          sustain_level,
  input  logic [AMP_W-1:0]          release_step,
  input  logic [TIME_W-1:0]         sustain_time,
  output logic [CHANNELS*OUT_W-1:0] env,
  output logic [CHANNELS-1:0]       idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  localparam logic [AMP_W:0]    AMP_MAX  = {1'b0, {AMP_W{1'b1}}};
  localparam logic [TIME_W-1:0] TIME_ONE = {{(TIME_W-1){1'b0}}, 1'b1};

  // Shared operands widened by one bit so no comparison can wrap.
  logic [AMP_W:0] atk_x;
  logic [AMP_W:0] rel_x;
  logic [AMP_W:0] sus_dec;

  assign atk_x   = {1'b0, attack_step};
  assign rel_x   = {1'b0, release_step};
  assign sus_dec = {1'b0, sustain_level} + {1'b0, decay_step};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t            state;
    logic [AMP_W-1:0]  amp;
    logic [TIME_W-1:0] timer;
    logic              gate_q;
    logic              pend;
    logic              rise;
    logic              trig;
    logic [AMP_W:0]    amp_x;
    logic [AMP_W:0]    sum;

    assign rise  = gate[i] & ~gate_q;
    assign trig  = pend | rise;
    assign amp_x = {1'b0, amp};
    assign sum   = amp_x + atk_x;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= S_IDLE;
        amp    <= '0;
        timer  <= '0;
        gate_q <= 1'b0;
        pend   <= 1'b0;
      end else begin
        gate_q <= gate[i];
        // A tick always consumes the pending trigger; a same-cycle edge is used directly.
        if (tick)
          pend <= 1'b0;
        else if (rise)
          pend <= 1'b1;

        if (tick) begin
          if (trig) begin
            state <= S_ATTACK;
            timer <= '0;
            if (LEGATO == 0)
              amp <= '0;
          end else if (!mode[i] && !gate[i] &&
                       (state == S_ATTACK || state == S_DECAY || state == S_SUSTAIN)) begin
            state <= S_RELEASE;
          end else begin
            unique case (state)
              S_IDLE: amp <= '0;
              S_ATTACK: begin
                if (sum >= AMP_MAX || attack_step == '0) begin
                  amp   <= '1;
                  state <= S_DECAY;
                end else begin
                  amp <= sum[AMP_W-1:0];
                end
              end
              S_DECAY: begin
                if (decay_step == '0 || amp_x <= sus_dec) begin
                  amp   <= sustain_level;
                  timer <= '0;
                  state <= S_SUSTAIN;
                end else begin
                  amp <= amp - decay_step;
                end
              end
              S_SUSTAIN: begin
                if (mode[i]) begin
                  if (timer >= sustain_time)
                    state <= S_RELEASE;
                  else
                    timer <= timer + TIME_ONE;
                end
              end
              S_RELEASE: begin
                if (release_step == '0 || amp_x <= rel_x) begin
                  amp   <= '0;
                  state <= S_IDLE;
                end else begin
                  amp <= amp - release_step;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      end
    end

    assign env[i*OUT_W +: OUT_W] = bypass ? '1 : amp[AMP_W-1 -: OUT_W];
    assign idle[i]               = (state == S_IDLE) & ~pend;
  end

endmodule

// File: tb/tb_adsr_envelope_multi.sv
// Directed bench: one LEGATO=0 instance with full-width outputs, one LEGATO=1 with 4-bit outputs.
module tb_adsr_envelope_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        bypass;
  logic [3:0]  gate;
  logic [3:0]  mode;
  logic [7:0]  attack_step;
  logic [7:0]  decay_step;
  logic [7:0]  sustain_level;
  logic [7:0]  release_step;
  logic [15:0] sustain_time;
  logic [31:0] env_a;
  logic [15:0] env_b;
  logic [3:0]  idle_a;
  logic [3:0]  idle_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adsr_envelope_multi #(
    .CHANNELS(4), .AMP_W(8), .OUT_W(8), .TIME_W(16), .LEGATO(0)
  ) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .gate(gate), .mode(mode), .bypass(bypass),
    .attack_step(attack_step), .decay_step(decay_step), .sustain_level(sustain_level),
    .release_step(release_step), .sustain_time(sustain_time), .env(env_a), .idle(idle_a)
  );

  adsr_envelope_multi #(
    .CHANNELS(4), .AMP_W(8), .OUT_W(4), .TIME_W(16), .LEGATO(1)
  ) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .gate(gate), .mode(mode), .bypass(bypass),
    .attack_step(attack_step), .decay_step(decay_step), .sustain_level(sustain_level),
    .release_step(release_step), .sustain_time(sustain_time), .env(env_b), .idle(idle_b)
  );

  typedef struct {
    logic [3:0] gate;
    logic [3:0] mode;
    logic       tick;
    logic [7:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_idle;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] s1 [14] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hDF, 8'hBF, 8'h9F, 8'h80,
                          8'h80, 8'h80, 8'h50, 8'h20, 8'h00};
  logic [7:0] s2 [16] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hDF, 8'hBF, 8'h9F, 8'h80,
                          8'h80, 8'h80, 8'h80, 8'h80, 8'h50, 8'h20, 8'h00};

  function automatic void add(input logic [3:0] g, input logic [3:0] m, input logic t,
                              input logic [7:0] ea, input logic [3:0] eb, input logic [3:0] ei);
    vec_t v;
    v.gate = g; v.mode = m; v.tick = t; v.exp_a = ea; v.exp_b = eb; v.exp_idle = ei;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gate  = '0;
    tick  = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; bypass = 1'b0; gate = '0; mode = '0;
    attack_step = 8'h40; decay_step = 8'h20; sustain_level = 8'h80;
    release_step = 8'h30; sustain_time = 16'd3;

    // Scenario 1: gated envelope on channel 0
    for (int k = 0; k < 14; k++)
      add((k < 10) ? 4'b0001 : 4'b0000, 4'b0000, 1'b1, s1[k], s1[k][7:4],
          (k == 13) ? 4'b1111 : 4'b1110);
    // Scenario 2: one-shot, sustain_time=3, gate held throughout
    for (int k = 0; k < 16; k++)
      add(4'b0001, 4'b0001, 1'b1, s2[k], s2[k][7:4], (k == 15) ? 4'b1111 : 4'b1110);
    add(4'b0001, 4'b0001, 1'b1, 8'h00, 4'h0, 4'b1111);
    add(4'b0000, 4'b0000, 1'b1, 8'h00, 4'h0, 4'b1111);
    // Scenario 3: retrigger during release at 0x50
    for (int k = 0; k < 9; k++)
      add(4'b0001, 4'b0000, 1'b1, s1[k], s1[k][7:4], 4'b1110);
    add(4'b0000, 4'b0000, 1'b1, 8'h80, 4'h8, 4'b1110);
    add(4'b0000, 4'b0000, 1'b1, 8'h50, 4'h5, 4'b1110);
    add(4'b0001, 4'b0000, 1'b1, 8'h00, 4'h5, 4'b1110);
    add(4'b0001, 4'b0000, 1'b1, 8'h40, 4'h9, 4'b1110);

    #3;
    check("reset env_a", env_a, 32'h0);
    check("reset env_b", {16'h0, env_b}, 32'h0);
    check("reset idle_a", {28'h0, idle_a}, 32'hF);
    bypass = 1'b1;
    #1;
    check("reset bypass env_b", {16'h0, env_b}, 32'hFFFF);
    bypass = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();

    for (int k = 0; k < vecs.size(); k++) begin
      gate = vecs[k].gate;
      mode = vecs[k].mode;
      tick = vecs[k].tick;
      cyc();
      check($sformatf("vec%0d amp_a", k), {24'h0, env_a[7:0]}, {24'h0, vecs[k].exp_a});
      check($sformatf("vec%0d env_b", k), {28'h0, env_b[3:0]}, {28'h0, vecs[k].exp_b});
      check($sformatf("vec%0d idle_a", k), {28'h0, idle_a}, {28'h0, vecs[k].exp_idle});
      check($sformatf("vec%0d idle_b", k), {28'h0, idle_b}, {28'h0, vecs[k].exp_idle});
    end

    // Scenario 4: one-clk pulse on channel 1 between ticks spaced 8 clks
    do_reset();
    mode = 4'b0010;
    gate = 4'b0010;
    cyc();
    gate = 4'b0000;
    check("s4 pend idle", {28'h0, idle_a}, 32'hD);
    repeat (6) cyc();
    check("s4 pend held", {28'h0, idle_a}, 32'hD);
    check("s4 amp before tick", {24'h0, env_a[15:8]}, 32'h00);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("s4 attack amp", {24'h0, env_a[15:8]}, 32'h00);
    check("s4 attack idle", {28'h0, idle_a}, 32'hD);
    repeat (7) cyc();
    check("s4 no-tick hold", {24'h0, env_a[15:8]}, 32'h00);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("s4 first step", {24'h0, env_a[15:8]}, 32'h40);
    repeat (7) cyc();
    check("s4 amp hold", {24'h0, env_a[15:8]}, 32'h40);

    // Scenario 5: zero attack/release steps and bypass
    do_reset();
    attack_step = 8'h00;
    release_step = 8'h00;
    mode = 4'b0000;
    gate = 4'b0100;
    tick = 1'b1;
    cyc();
    check("s5 attack idle", {28'h0, idle_a}, 32'hB);
    cyc();
    check("s5 amp max", {24'h0, env_a[23:16]}, 32'hFF);
    tick = 1'b0;
    bypass = 1'b1;
    #1;
    check("s5 bypass env_a", env_a, 32'hFFFFFFFF);
    check("s5 bypass env_b", {16'h0, env_b}, 32'hFFFF);
    bypass = 1'b0;
    #1;
    check("s5 unbypass env_a", env_a, 32'h00FF0000);
    gate = 4'b0000;
    tick = 1'b1;
    cyc();
    check("s5 gate-off hold", {24'h0, env_a[23:16]}, 32'hFF);
    cyc();
    check("s5 release to 0", {24'h0, env_a[23:16]}, 32'h00);
    check("s5 release idle", {28'h0, idle_a}, 32'hF);
    attack_step = 8'h40;
    release_step = 8'h30;

    // Scenario 6: simultaneous triggers, then asynchronous reset mid-attack
    do_reset();
    mode = 4'b1000;
    gate = 4'b1001;
    tick = 1'b1;
    cyc();
    check("s6 both attack idle", {28'h0, idle_a}, 32'h6);
    cyc();
    check("s6 first step", env_a, 32'h40000040);
    cyc();
    check("s6 second step", env_a, 32'h80000080);
    check("s6 env_b", {16'h0, env_b}, 32'h8008);
    #2;
    reset = 1'b1;
    #1;
    check("s6 async env_a", env_a, 32'h0);
    check("s6 async env_b", {16'h0, env_b}, 32'h0);
    check("s6 async idle_a", {28'h0, idle_a}, 32'hF);
    check("s6 async idle_b", {28'h0, idle_b}, 32'hF);
    tick = 1'b0;
    gate = '0;
    cyc();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adsr_envelope_multi.md
Name: adsr_envelope_multi

Overview:
Parametrised multi-channel ADSR envelope generator. It replaces the single-channel volume shaper.
- Per channel: gate-driven (held-note) or one-shot (timed sustain) operation.
- All channels advance on a shared sample-rate tick strobe, for example from the clock divider.
- Envelope words feed the per-channel amplitude multipliers after the waveform generators.

Parameters:
CHANNELS, 4, number of independent envelope channels
AMP_W, 12, amplitude accumulator width; MAX = 2^AMP_W-1
OUT_W, 8, envelope output width per channel; top OUT_W bits of the accumulator, OUT_W <= AMP_W
TIME_W, 16, sustain timer width
LEGATO, 0, 0 = retrigger restarts amplitude at 0; 1 = retrigger attacks from the current amplitude

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
tick  in  1  one-clk strobe; envelope state advances only on clk edges where tick=1
gate  in  CHANNELS  per-channel note gate; a rising edge triggers that channel
mode  in  CHANNELS  per channel: 0 = gated sustain, 1 = one-shot timed sustain
bypass  in  1  1 = all env outputs forced to all-ones; state machines keep running
attack_step  in  AMP_W  amplitude increment per tick in ATTACK (shared by all channels)
decay_step  in  AMP_W  decrement per tick in DECAY
sustain_level  in  AMP_W  SUSTAIN amplitude
release_step  in  AMP_W  decrement per tick in RELEASE
sustain_time  in  TIME_W  ticks spent in SUSTAIN in one-shot mode
env  out  CHANNELS*OUT_W  channel i occupies bits [i*OUT_W +: OUT_W]
idle  out  CHANNELS  1 = channel in IDLE with no pending trigger

Behaviour:
- Reset: state=IDLE, amp=0, timer=0, pend=0, gate_q=0 for all channels; env=0 (or all-ones if bypass=1, since it is combinational on bypass); idle=all ones.
- Per-channel registers: state, amp[AMP_W], timer[TIME_W], gate_q, pend.
- gate_q <= gate every clk.
- pend set on any clk where gate & ~gate_q. It is cleared on the tick that consumes it.
- On a tick, the effective trigger is pend OR a same-cycle rising edge.
- The tick is the only state-advance point. Without a tick, state, amp and timer hold; only gate_q and pend update.
- Priority on a tick, per channel:
  1. Trigger: state<=ATTACK; amp<=0 if LEGATO=0, else unchanged; timer<=0. Applies from any state.
  2. Gate-off (mode=0, gate=0, state in ATTACK/DECAY/SUSTAIN): state<=RELEASE, amp unchanged.
  3. Normal progression, below.
- All arithmetic is done in AMP_W+1 bits. No wrap-around is ever allowed.
- IDLE: amp held at 0.
- ATTACK:
  - sum = amp + attack_step.
  - If sum >= MAX or attack_step=0: amp<=MAX, ->DECAY.
  - Else amp<=sum.
- DECAY:
  - If decay_step=0, or amp <= sustain_level + decay_step: amp<=sustain_level, timer<=0, ->SUSTAIN.
  - Else amp<=amp-decay_step.
  - sustain_level above the current amp also exits to SUSTAIN at sustain_level.
- SUSTAIN, amp held:
  - mode=0: stays until gate-off.
  - mode=1: if timer >= sustain_time, ->RELEASE; else timer<=timer+1. sustain_time=0 gives exactly 1 tick in SUSTAIN.
- RELEASE:
  - If release_step=0 or amp <= release_step: amp<=0, ->IDLE.
  - Else amp<=amp-release_step.
- env[i] = bypass ? all-ones : amp_i[AMP_W-1 -: OUT_W]. It is combinational from the amp register, so it has zero extra latency after the advancing tick edge.
- idle[i] = (state==IDLE) & ~pend. Registered-state derived.
- Latency:
  - Gate rise at edge k with no tick: ATTACK entered at the first tick edge after k.
  - Tick at edge k with the rise visible: ATTACK entered at k.
  - First nonzero amp appears one tick after entering ATTACK (LEGATO=0).
- Channels are fully independent; simultaneous triggers on several channels are all honoured on the same tick.
- Reset mid-envelope returns every channel to the reset values immediately, with no release ramp.
- Step inputs are sampled on each tick. Changing them mid-envelope takes effect on the next tick.

Test Plan:
1. AMP_W=8, OUT_W=4, mode=0, attack=0x40, decay=0x20, sustain=0x80, release=0x30. Gate rise then tick each cycle -> amp 0x00,0x40,0x80,0xC0,0xFF (DECAY),0xDF,0xBF,0x9F,0x80 (SUSTAIN) and holds; gate low -> 0x50,0x20,0x00, idle=1.
2. Same config, mode=1, sustain_time=3 -> SUSTAIN lasts 4 ticks at 0x80, then the release ramp of scenario 1 runs with gate still high.
3. Retrigger during RELEASE at amp 0x50: LEGATO=0 -> next tick amp=0x00, ATTACK; LEGATO=1 -> next tick 0x50, then 0x90.
4. Gate pulse of 1 clk between ticks spaced 8 clks -> pend held; ATTACK at the next tick; idle=0 from the clk after the pulse.
5. attack_step=0, release_step=0 -> amp MAX after 1 tick; gate-off -> amp 0 and IDLE in 1 tick; bypass=1 -> env=0xF on all channels regardless of state.
6. CHANNELS=4, channels 0 and 3 triggered on the same tick with different modes; assert reset mid-ATTACK -> all env=0, idle=4'b1111 immediately, without waiting for a clk edge.
